// File: rtl/psum_col_collector_if.sv
// Row-collector bus: skewed psum writes in, aligned FWFT row and status flags out.
// master = array/reader side, slave = collector.
interface psum_col_collector_if #(
    parameter int unsigned psum_bw = 16,
    parameter int unsigned col     = 8
);
    logic [psum_bw*col-1:0] in_s;
    logic [col-1:0]         valid_in;
    logic                   rd;
    logic [psum_bw*col-1:0] out;
    logic                   o_valid;
    logic                   o_full;
    logic [col-1:0]         o_overflow;

    modport master (
        output in_s, valid_in, rd,
        input  out, o_valid, o_full, o_overflow
    );

    modport slave (
        input  in_s, valid_in, rd,
        output out, o_valid, o_full, o_overflow
    );
endinterface

// File: rtl/psum_col_collector.sv
// South-side psum collector: one FWFT FIFO per column de-skews the array outputs into rows.
// Optional macro PSUM_RELU_EN clamps negative output slices to zero.
module psum_col_collector #(
    parameter int unsigned psum_bw = 16,
    parameter int unsigned col     = 8,
    parameter int unsigned depth   = 16
) (
    input logic                clk,
    input logic                reset,
    psum_col_collector_if.slave bus
);
    localparam int unsigned AW = $clog2(depth);
    typedef logic [AW:0] cnt_t;
    localparam cnt_t CntFull = cnt_t'(depth);

    logic [psum_bw-1:0] r_mem  [col][depth];
    logic [AW-1:0]      r_wptr [col];
    logic [AW-1:0]      r_rptr [col];
    cnt_t               r_cnt  [col];
    logic [col-1:0]     r_ovf;

    logic               w_pop;
    logic [col-1:0]     w_nonempty;
    logic [col-1:0]     w_full;
    logic [col-1:0]     w_wr;
    logic [col-1:0]     w_drop;
    logic [psum_bw-1:0] w_head [col];

    always_comb begin
        w_nonempty = '0;
        w_full     = '0;
        for (int c = 0; c < col; c++) begin
            w_nonempty[c] = (r_cnt[c] != '0);
            w_full[c]     = (r_cnt[c] == CntFull);
        end
    end

    assign bus.o_valid    = &w_nonempty;
    assign bus.o_full     = |w_full;
    assign bus.o_overflow = r_ovf;
    assign w_pop          = bus.rd & bus.o_valid;

    // A pop frees a slot in every column, so a full column can still accept that cycle.
    always_comb begin
        w_wr   = '0;
        w_drop = '0;
        for (int c = 0; c < col; c++) begin
            w_wr[c]   = bus.valid_in[c] & (~w_full[c] | w_pop);
            w_drop[c] = bus.valid_in[c] & w_full[c] & ~w_pop;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < col; c++) begin
                r_wptr[c] <= '0;
                r_rptr[c] <= '0;
                r_cnt[c]  <= '0;
            end
            r_ovf <= '0;
        end else begin
            for (int c = 0; c < col; c++) begin
                if (w_wr[c]) r_wptr[c] <= r_wptr[c] + 1'b1;
                if (w_pop)   r_rptr[c] <= r_rptr[c] + 1'b1;
                if (w_wr[c] && !w_pop) begin
                    r_cnt[c] <= r_cnt[c] + 1'b1;
                end else if (!w_wr[c] && w_pop) begin
                    r_cnt[c] <= r_cnt[c] - 1'b1;
                end
            end
            r_ovf <= r_ovf | w_drop;
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < col; c++) begin
            if (w_wr[c]) r_mem[c][r_wptr[c]] <= bus.in_s[c*psum_bw +: psum_bw];
        end
    end

    always_comb begin
        for (int c = 0; c < col; c++) begin
            w_head[c] = r_mem[c][r_rptr[c]];
`ifdef PSUM_RELU_EN
            if (w_head[c][psum_bw-1]) w_head[c] = '0;
`endif
        end
    end

    always_comb begin
        bus.out = '0;
        if (bus.o_valid) begin
            for (int c = 0; c < col; c++) begin
                bus.out[c*psum_bw +: psum_bw] = w_head[c];
            end
        end
    end
endmodule

// File: tb/tb_psum_col_collector.sv
// Directed bench for psum_col_collector with a per-column queue scoreboard.
module tb_psum_col_collector;
    localparam int unsigned PW = 16;
    localparam int unsigned NC = 8;
    localparam int unsigned DP = 16;
    localparam int unsigned VW = PW*NC;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    psum_col_collector_if #(.psum_bw(PW), .col(NC)) bus ();

    psum_col_collector #(.psum_bw(PW), .col(NC), .depth(DP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [PW-1:0] sb [NC][$];
    logic [NC-1:0] m_ovf = '0;
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic m_valid();
        for (int c = 0; c < NC; c++) if (sb[c].size() == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic m_full();
        for (int c = 0; c < NC; c++) if (sb[c].size() == DP) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [VW-1:0] m_out();
        logic [VW-1:0] v;
        logic [PW-1:0] h;
        v = '0;
        if (!m_valid()) return v;
        for (int c = 0; c < NC; c++) begin
            h = sb[c][0];
`ifdef PSUM_RELU_EN
            if (h[PW-1]) h = '0;
`endif
            v[c*PW +: PW] = h;
        end
        return v;
    endfunction

    function automatic logic [VW-1:0] rowv(input logic [PW-1:0] x);
        return {NC{x}};
    endfunction

    // Distinct value per column and row: column in high byte, row in low byte.
    function automatic logic [VW-1:0] rowd(input int r);
        logic [VW-1:0] v;
        for (int c = 0; c < NC; c++) v[c*PW +: PW] = PW'((c << 8) | (r & 8'hFF));
        return v;
    endfunction

    function automatic logic [VW-1:0] rnd_vec();
        logic [VW-1:0] v;
        for (int i = 0; i < VW/32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic reset_model();
        for (int c = 0; c < NC; c++) sb[c].delete();
        m_ovf = '0;
    endtask

    task automatic step(input logic [NC-1:0] v, input logic [VW-1:0] d, input logic r,
                        input string tag);
        logic pop;
        pop = r && m_valid();
        for (int c = 0; c < NC; c++) begin
            if (pop) void'(sb[c].pop_front());
            if (v[c]) begin
                if (sb[c].size() < DP) sb[c].push_back(d[c*PW +: PW]);
                else m_ovf[c] = 1'b1;
            end
        end
        bus.valid_in = v;
        bus.in_s     = d;
        bus.rd       = r;
        @(posedge clk);
        #1;
        bus.valid_in = '0;
        bus.rd       = 1'b0;
        chk({tag, ".valid"}, VW'(bus.o_valid), VW'(m_valid()));
        chk({tag, ".full"},  VW'(bus.o_full),  VW'(m_full()));
        chk({tag, ".ovf"},   VW'(bus.o_overflow), VW'(m_ovf));
        chk({tag, ".out"},   bus.out, m_out());
    endtask

    initial begin
        logic [VW-1:0] d;
        logic [VW-1:0] e;

        bus.in_s = '0; bus.valid_in = '0; bus.rd = 1'b0;
        #1 reset = 1'b0;
        #2;
        chk("rst.valid", VW'(bus.o_valid), '0);
        chk("rst.full",  VW'(bus.o_full), '0);
        chk("rst.ovf",   VW'(bus.o_overflow), '0);
        chk("rst.out",   bus.out, '0);
        @(posedge clk); @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk); #1;

        // Skewed fill: one column per cycle, column c carries c+1.
        e = '0;
        for (int c = 0; c < NC; c++) begin
            d = rnd_vec();
            d[c*PW +: PW] = PW'(c + 1);
            e[c*PW +: PW] = PW'(c + 1);
            step(NC'(1) << c, d, 1'b0, "skew");
            if (c == NC - 2) chk("skew.valid_early", VW'(bus.o_valid), VW'(0));
        end
        chk("skew.valid_rise", VW'(bus.o_valid), VW'(1));
        chk("skew.row", bus.out, e);
        step('0, '0, 1'b1, "skew_pop");

        // FWFT: three aligned rows then continuous reads.
        step('1, rowv(16'd10), 1'b0, "fwft_wr");
        step('1, rowv(16'd20), 1'b0, "fwft_wr");
        step('1, rowv(16'd30), 1'b0, "fwft_wr");
        chk("fwft.head10", bus.out, rowv(16'd10));
        step('0, '0, 1'b1, "fwft_rd");
        chk("fwft.head20", bus.out, rowv(16'd20));
        step('0, '0, 1'b1, "fwft_rd");
        chk("fwft.head30", bus.out, rowv(16'd30));
        step('0, '0, 1'b1, "fwft_rd");
        chk("fwft.drained", VW'(bus.o_valid), VW'(0));
        step('0, '0, 1'b1, "rd_empty");

        // Fill to depth, then write+pop while full, then overflow one column.
        for (int r = 0; r < DP; r++) step('1, rowd(r), 1'b0, "fill");
        chk("fill.full", VW'(bus.o_full), VW'(1));
        step('1, rowd(16), 1'b1, "full_wrpop");
        chk("full_wrpop.full", VW'(bus.o_full), VW'(1));
        chk("full_wrpop.ovf", VW'(bus.o_overflow), VW'(0));
        step(8'h08, rowd(17), 1'b0, "ovf");
        chk("ovf.flag", VW'(bus.o_overflow), VW'(8'h08));
        chk("ovf.head", bus.out, rowd(1));
        for (int i = 0; i < DP; i++) begin
            step('0, '0, 1'b1, "drain");
            if (i == DP - 2) chk("drain.row16", bus.out, rowd(16));
        end
        chk("drain.empty", VW'(bus.o_valid), VW'(0));

        // Asynchronous reset between edges with data buffered and overflow set.
        for (int r = 0; r < 5; r++) step('1, rowd(40 + r), 1'b0, "pre_rst");
        chk("pre_rst.valid", VW'(bus.o_valid), VW'(1));
        #3 reset = 1'b0;
        reset_model();
        #1;
        chk("arst.valid", VW'(bus.o_valid), '0);
        chk("arst.full",  VW'(bus.o_full), '0);
        chk("arst.ovf",   VW'(bus.o_overflow), '0);
        chk("arst.out",   bus.out, '0);
        #1 reset = 1'b1;
        step('1, rowd(60), 1'b0, "refill");
        chk("refill.row", bus.out, rowd(60));
        step('0, '0, 1'b1, "refill_pop");
        chk("refill.empty", VW'(bus.o_valid), VW'(0));

        // Output clamp on negative slices.
        d = '0;
        d[0*PW +: PW] = 16'hFFF6;
        d[1*PW +: PW] = 16'h0005;
        for (int c = 2; c < NC; c++) d[c*PW +: PW] = PW'((c[0] ? 16'h8000 : 16'h0000) | c);
        step('1, d, 1'b0, "clamp");
`ifdef PSUM_RELU_EN
        chk("clamp.c01", VW'(bus.out[2*PW-1:0]), VW'({16'h0005, 16'h0000}));
`else
        chk("clamp.c01", VW'(bus.out[2*PW-1:0]), VW'({16'h0005, 16'hFFF6}));
`endif
        step('0, '0, 1'b1, "clamp_pop");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
